// File: rtl/time_cmd_scheduler_if.sv
// UART receive byte stream into the command scheduler (valid/ready handshake).
interface time_cmd_scheduler_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/time_cmd_scheduler.sv
// Command scheduler: decodes UART command bytes into a 4-entry FIFO, arbitrates them
// against button events and issues one mode-gated control pulse per issue slot.
module time_cmd_scheduler #(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   time_cmd_scheduler_if.slave rx,
   input  logic                btn_L,
   input  logic                btn_R,
   input  logic                btn_U,
   input  logic                btn_D,
   input  logic [1:0]          mode,
   output logic                o_runstop,
   output logic                o_clear,
   output logic                o_secup,
   output logic                o_minup,
   output logic                o_hourup,
   output logic                o_digit_mode,
   output logic                o_watch_mode,
   output logic                o_cmd_err
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 2;
   localparam int unsigned CW    = 3;
   localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned NP    = 5;
   localparam int unsigned P_RUN  = 0;
   localparam int unsigned P_CLR  = 1;
   localparam int unsigned P_SEC  = 2;
   localparam int unsigned P_MIN  = 3;
   localparam int unsigned P_HOUR = 4;

   typedef enum logic [2:0] {
      CMD_RUN, CMD_CLR, CMD_SEC, CMD_MIN, CMD_HOUR, CMD_DIG, CMD_WAT, CMD_REL
   } cmd_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_e;
   typedef enum logic [1:0] {OVR_NONE, OVR_DIG, OVR_WAT, OVR_REL} ovr_op_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [3:0]      pend_q, pend_d;
   cmd_e            mem_q [DEPTH];
   cmd_e            mem_d [DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NP-1:0]   pulse_q, pulse_d;
   logic            err_q, err_d;
   ovr_op_e         ovr_op_q, ovr_op_d;
   logic [1:0]      ovr_en_q, ovr_en_d;
   logic [1:0]      ovr_val_q, ovr_val_d;
   logic [1:0]      mode_prev_q, mode_prev_d;

   logic [7:0]      rx_up;
   logic            rx_known;
   cmd_e            rx_cmd;
   logic            fifo_full;
   logic            push, pop;
   logic            can_sel;
   logic [1:0]      mode_edge, ovr_act, eff;
   logic            wm;
   logic [3:0]      pend_clr;
   cmd_e            head;

   // Case-insensitive decode of the incoming command byte
   always_comb begin
      rx_up    = rx.rx_data & 8'hDF;
      rx_known = 1'b1;
      rx_cmd   = CMD_RUN;
      case (rx_up)
         8'h52:   rx_cmd = CMD_RUN;
         8'h43:   rx_cmd = CMD_CLR;
         8'h53:   rx_cmd = CMD_SEC;
         8'h4D:   rx_cmd = CMD_MIN;
         8'h48:   rx_cmd = CMD_HOUR;
         8'h44:   rx_cmd = CMD_DIG;
         8'h57:   rx_cmd = CMD_WAT;
         8'h58:   rx_cmd = CMD_REL;
         default: rx_known = 1'b0;
      endcase
   end

   assign fifo_full   = (cnt_q == CW'(DEPTH));
   assign rx.rx_ready = ~fifo_full;
   assign push        = rx.rx_valid & ~fifo_full & rx_known;
   assign head        = mem_q[rd_q];

   // A switch edge masks the override in the same cycle it clears it
   always_comb begin
      mode_edge    = mode ^ mode_prev_q;
      ovr_act      = ovr_en_q & ~mode_edge;
      eff          = (ovr_act & ovr_val_q) | (~ovr_act & mode);
      wm           = eff[1];
      o_digit_mode = eff[0];
      o_watch_mode = eff[1];
   end

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      pulse_d     = '0;
      err_d       = rx.rx_valid & ~fifo_full & ~rx_known;
      ovr_op_d    = OVR_NONE;
      ovr_en_d    = ovr_en_q;
      ovr_val_d   = ovr_val_q;
      mode_prev_d = mode;
      pend_clr    = '0;
      pop         = 1'b0;
      mem_d       = mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;

      case (state_q)
         ST_ISSUE: begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
            case (ovr_op_q)
               OVR_DIG: begin ovr_en_d[0] = 1'b1; ovr_val_d[0] = ~eff[0]; end
               OVR_WAT: begin ovr_en_d[1] = 1'b1; ovr_val_d[1] = ~eff[1]; end
               OVR_REL: ovr_en_d = '0;
               default: ;
            endcase
         end
         ST_GAP: begin
            if (gap_q != '0) gap_d = gap_q - GW'(1);
            else             state_d = ST_IDLE;
         end
         default: ;
      endcase

      // Selection runs in IDLE and in the final GAP cycle so slots are GAP_CYCLES+1 apart
      can_sel = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0));
      if (can_sel && (pend_q != '0)) begin
         state_d = ST_ISSUE;
         if (pend_q[0]) begin
            pend_clr[0] = 1'b1;
            pulse_d[P_RUN] = ~wm;
         end else if (pend_q[1]) begin
            pend_clr[1] = 1'b1;
            if (wm) pulse_d[P_MIN] = 1'b1;
            else    pulse_d[P_CLR] = 1'b1;
         end else if (pend_q[2]) begin
            pend_clr[2] = 1'b1;
            pulse_d[P_SEC] = wm;
         end else begin
            pend_clr[3] = 1'b1;
            pulse_d[P_HOUR] = wm;
         end
      end else if (can_sel && (cnt_q != '0)) begin
         state_d = ST_ISSUE;
         pop     = 1'b1;
         case (head)
            CMD_RUN:  if (!wm) pulse_d[P_RUN]  = 1'b1; else err_d = 1'b1;
            CMD_CLR:  if (!wm) pulse_d[P_CLR]  = 1'b1; else err_d = 1'b1;
            CMD_SEC:  if (wm)  pulse_d[P_SEC]  = 1'b1; else err_d = 1'b1;
            CMD_MIN:  if (wm)  pulse_d[P_MIN]  = 1'b1; else err_d = 1'b1;
            CMD_HOUR: if (wm)  pulse_d[P_HOUR] = 1'b1; else err_d = 1'b1;
            CMD_DIG:  ovr_op_d = OVR_DIG;
            CMD_WAT:  ovr_op_d = OVR_WAT;
            default:  ovr_op_d = OVR_REL;
         endcase
      end

      ovr_en_d = ovr_en_d & ~mode_edge;
      pend_d   = (pend_q & ~pend_clr) | {btn_D, btn_U, btn_L, btn_R};

      if (push) begin
         mem_d[wr_q] = rx_cmd;
         wr_d        = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         gap_q       <= '0;
         pend_q      <= '0;
         mem_q       <= '{default: CMD_RUN};
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         pulse_q     <= '0;
         err_q       <= 1'b0;
         ovr_op_q    <= OVR_NONE;
         ovr_en_q    <= '0;
         ovr_val_q   <= '0;
         mode_prev_q <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         pend_q      <= pend_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         pulse_q     <= pulse_d;
         err_q       <= err_d;
         ovr_op_q    <= ovr_op_d;
         ovr_en_q    <= ovr_en_d;
         ovr_val_q   <= ovr_val_d;
         mode_prev_q <= mode_prev_d;
      end
   end

   assign o_runstop = pulse_q[P_RUN];
   assign o_clear   = pulse_q[P_CLR];
   assign o_secup   = pulse_q[P_SEC];
   assign o_minup   = pulse_q[P_MIN];
   assign o_hourup  = pulse_q[P_HOUR];
   assign o_cmd_err = err_q;

endmodule
